// File: rtl/ppu_bg_pixel_fifo_if.sv
// ppu_bg_pixel_fifo_if
// Handshake bundle between the BG fetcher / LCD sink and the background pixel FIFO.
//   load_valid, load_lo, load_hi : fetcher presents one two-plane tile row
//   load_ready                   : FIFO has room for a full row
//   px_valid, px_out             : FIFO presents one shaded pixel
//   px_ready                     : sink accepts the pixel
// Modports: master = fetcher/sink side, slave = FIFO side.
interface ppu_bg_pixel_fifo_if #(
    parameter int ROW_PX = 8
);
    logic              load_valid;
    logic              load_ready;
    logic [ROW_PX-1:0] load_lo;
    logic [ROW_PX-1:0] load_hi;
    logic              px_valid;
    logic              px_ready;
    logic [1:0]        px_out;

    modport master (
        output load_valid, load_lo, load_hi, px_ready,
        input  load_ready, px_valid, px_out
    );

    modport slave (
        input  load_valid, load_lo, load_hi, px_ready,
        output load_ready, px_valid, px_out
    );
endinterface

// File: rtl/ppu_bg_pixel_fifo.sv
// ppu_bg_pixel_fifo
// Background pixel FIFO for the PPU draw path. Takes whole tile rows from the
// BG fetcher, drops the SCX fine-scroll pixels at line start, maps colour
// indices through BGP and emits one shade per cycle toward the LCD sink.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   flush              : synchronous clear of storage, discard and column state
//   discard_set/_n     : load the fine-scroll discard counter
//   bg_enable, palette : LCDC[0] and BGP, applied combinationally at emit time
//   bus (slave)        : tile row load handshake and pixel output handshake
//   count              : pixels currently stored
//   x_out              : pixels emitted this line
//   line_done          : sticky end-of-line flag, cleared by flush
module ppu_bg_pixel_fifo #(
    parameter int DEPTH   = 16,
    parameter int ROW_PX  = 8,
    parameter int LINE_PX = 160,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               discard_set,
    input  logic [2:0]         discard_n,
    input  logic               bg_enable,
    input  logic [7:0]         palette,
    ppu_bg_pixel_fifo_if.slave bus,
    output logic [CNT_W-1:0]   count,
    output logic [7:0]         x_out,
    output logic               line_done
);

    logic [1:0]       mem [DEPTH];
    logic [1:0]       row_px [ROW_PX];

    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [2:0]       discard_reg, discard_next;
    logic [7:0]       x_reg, x_next;
    logic             done_reg, done_next;

    logic             load_fire;
    logic             discard_pop;
    logic             emit_pop;
    logic             pop;
    logic [1:0]       idx;

    // Row entry k leaves first for k=0, so it takes the leftmost (MSB) bits.
    generate
        for (genvar gi = 0; gi < ROW_PX; gi++) begin : g_row
            assign row_px[gi] = {bus.load_hi[ROW_PX-1-gi], bus.load_lo[ROW_PX-1-gi]};
        end
    endgenerate

    // Room is judged on the pre-update count, so a pop in the same cycle does
    // not open space for a load until the next cycle.
    assign bus.load_ready = (count_reg <= CNT_W'(DEPTH - ROW_PX)) && !flush;
    assign load_fire      = bus.load_valid && bus.load_ready;

    assign discard_pop  = (discard_reg != 3'd0) && (count_reg != '0);
    assign bus.px_valid = (count_reg != '0) && (discard_reg == 3'd0) && !done_reg;
    assign emit_pop     = bus.px_valid && bus.px_ready;
    assign pop          = discard_pop || emit_pop;

    // Head read is combinational so a row loaded into an empty FIFO is
    // visible on the very next cycle.
    assign idx        = mem[rd_ptr_reg];
    assign bus.px_out = (bus.px_valid && bg_enable) ? palette[{idx, 1'b0} +: 2] : 2'b00;

    assign count     = count_reg;
    assign x_out     = x_reg;
    assign line_done = done_reg;

    always_comb begin
        count_next   = count_reg;
        rd_ptr_next  = rd_ptr_reg;
        wr_ptr_next  = wr_ptr_reg;
        discard_next = discard_reg;
        x_next       = x_reg;
        done_next    = done_reg;

        if (flush) begin
            count_next   = '0;
            rd_ptr_next  = '0;
            wr_ptr_next  = '0;
            x_next       = 8'd0;
            done_next    = 1'b0;
            discard_next = discard_set ? discard_n : 3'd0;
        end else begin
            count_next = count_reg
                       + (load_fire ? CNT_W'(ROW_PX) : CNT_W'(0))
                       - (pop ? CNT_W'(1) : CNT_W'(0));

            // The write pointer only ever holds multiples of ROW_PX, so a
            // row never straddles the wrap point.
            if (load_fire) begin
                wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - ROW_PX)) ? '0
                            : wr_ptr_reg + PTR_W'(ROW_PX);
            end

            if (pop) begin
                rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0
                            : rd_ptr_reg + PTR_W'(1);
            end

            // A fresh discard request overrides an in-progress countdown.
            if (discard_set) begin
                discard_next = discard_n;
            end else if (discard_pop) begin
                discard_next = discard_reg - 3'd1;
            end

            if (emit_pop) begin
                x_next = x_reg + 8'd1;
                if (x_reg == 8'(LINE_PX - 1)) begin
                    done_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            rd_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            discard_reg <= 3'd0;
            x_reg       <= 8'd0;
            done_reg    <= 1'b0;
        end else begin
            count_reg   <= count_next;
            rd_ptr_reg  <= rd_ptr_next;
            wr_ptr_reg  <= wr_ptr_next;
            discard_reg <= discard_next;
            x_reg       <= x_next;
            done_reg    <= done_next;
        end
    end

    // Storage contents are meaningless while count is zero, so they need no reset.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int k = 0; k < ROW_PX; k++) begin
                mem[wr_ptr_reg + PTR_W'(k)] <= row_px[k];
            end
        end
    end

endmodule

// File: tb/tb_ppu_bg_pixel_fifo.sv
module tb_ppu_bg_pixel_fifo;

    localparam int DEPTH   = 16;
    localparam int ROW_PX  = 8;
    localparam int LINE_PX = 160;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       discard_set;
    logic [2:0] discard_n;
    logic       bg_enable;
    logic [7:0] palette;
    logic [4:0] count;
    logic [7:0] x_out;
    logic       line_done;

    ppu_bg_pixel_fifo_if #(.ROW_PX(ROW_PX)) bus();

    ppu_bg_pixel_fifo #(
        .DEPTH(DEPTH),
        .ROW_PX(ROW_PX),
        .LINE_PX(LINE_PX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .discard_set(discard_set),
        .discard_n(discard_n),
        .bg_enable(bg_enable),
        .palette(palette),
        .bus(bus),
        .count(count),
        .x_out(x_out),
        .line_done(line_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of colour indices in output order.
    int q[$];
    int m_disc;
    int m_x;
    bit m_done;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_disc = 0;
        m_x    = 0;
        m_done = 0;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance
    // the model with the inputs seen this cycle. Returns at posedge+1.
    task automatic cycle();
        int  exp_valid, exp_out, exp_ready;
        bit  do_load, discarding, emitting;
        int  lo, hi;
        @(negedge clk);
        exp_valid = (q.size() > 0 && m_disc == 0 && !m_done) ? 1 : 0;
        exp_out   = (exp_valid && bg_enable) ? ((palette >> (2 * q[0])) & 3) : 0;
        exp_ready = (q.size() <= DEPTH - ROW_PX && !flush) ? 1 : 0;
        check("px_valid", int'(bus.px_valid), exp_valid);
        check("px_out", int'(bus.px_out), exp_out);
        check("load_ready", int'(bus.load_ready), exp_ready);
        check("count", int'(count), q.size());
        check("x_out", int'(x_out), m_x);
        check("line_done", int'(line_done), int'(m_done));

        do_load    = bus.load_valid && exp_ready;
        discarding = (m_disc > 0 && q.size() > 0);
        emitting   = exp_valid && bus.px_ready;
        lo = int'(bus.load_lo);
        hi = int'(bus.load_hi);
        if (flush) begin
            model_reset();
            m_disc = discard_set ? int'(discard_n) : 0;
        end else begin
            if (discarding || emitting) void'(q.pop_front());
            if (emitting) begin
                m_x++;
                if (m_x == LINE_PX) m_done = 1;
            end
            if (discard_set) m_disc = int'(discard_n);
            else if (discarding) m_disc--;
            if (do_load) begin
                for (int k = 0; k < ROW_PX; k++)
                    q.push_back(((hi >> (ROW_PX - 1 - k)) & 1) * 2 + ((lo >> (ROW_PX - 1 - k)) & 1));
            end
        end
        @(posedge clk);
        #1;
    endtask

    int shades1[8] = '{3, 3, 1, 1, 2, 2, 0, 0};

    initial begin
        rst            = 1'b1;
        flush          = 1'b0;
        discard_set    = 1'b0;
        discard_n      = 3'd0;
        bg_enable      = 1'b1;
        palette        = 8'hE4;
        bus.load_valid = 1'b0;
        bus.load_lo    = '0;
        bus.load_hi    = '0;
        bus.px_ready   = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("rst_px_valid", int'(bus.px_valid), 0);
        check("rst_px_out", int'(bus.px_out), 0);
        check("rst_load_ready", int'(bus.load_ready), 1);
        check("rst_count", int'(count), 0);
        check("rst_x_out", int'(x_out), 0);
        check("rst_line_done", int'(line_done), 0);
        rst = 1'b0;

        // Basic row: shades 3,3,1,1,2,2,0,0
        bus.load_valid = 1'b1;
        bus.load_lo    = 8'hF0;
        bus.load_hi    = 8'hCC;
        bus.px_ready   = 1'b1;
        cycle();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t1_valid", int'(bus.px_valid), 1);
            check("t1_shade", int'(bus.px_out), shades1[i]);
            cycle();
        end
        check("t1_x_out", int'(x_out), 8);
        $display("t1 basic row done");

        // Line start with fine-scroll discard of 3
        flush = 1'b1; discard_set = 1'b1; discard_n = 3'd3;
        cycle();
        flush = 1'b0; discard_set = 1'b0;
        bus.load_valid = 1'b1; bus.load_lo = 8'hFF; bus.load_hi = 8'h00;
        cycle();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_valid", int'(bus.px_valid), (i >= 3) ? 1 : 0);
            if (i >= 3) check("t2_shade", int'(bus.px_out), 1);
            cycle();
        end
        check("t2_x_out", int'(x_out), 5);
        $display("t2 discard done");

        // Fill to full with the sink stalled, then drain until a row fits
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.px_ready = 1'b0;
        bus.load_valid = 1'b1; bus.load_lo = 8'h5A; bus.load_hi = 8'h96;
        cycle();
        cycle();
        #1;
        check("t3_full_count", int'(count), 16);
        check("t3_full_ready", int'(bus.load_ready), 0);
        cycle();
        bus.px_ready = 1'b1;
        for (int i = 0; i < 12 && q.size() > DEPTH - ROW_PX; i++) cycle();
        cycle();
        bus.load_valid = 1'b0;
        #1;
        check("t3_refill_count", int'(count), 15);
        $display("t3 full handling done");

        // Full line with continuous loads
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 180; i++) begin
            bus.load_lo = 8'($urandom);
            bus.load_hi = 8'($urandom);
            cycle();
        end
        #1;
        check("t4_x_out", int'(x_out), LINE_PX);
        check("t4_line_done", int'(line_done), 1);
        check("t4_valid_after", int'(bus.px_valid), 0);
        bus.load_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        #1;
        check("t4_flush_x", int'(x_out), 0);
        check("t4_flush_done", int'(line_done), 0);
        check("t4_flush_count", int'(count), 0);
        $display("t4 line end done");

        // Background disable forces shade 0, re-enable takes effect at once
        bg_enable = 1'b0; palette = 8'hFF;
        bus.load_valid = 1'b1; bus.load_lo = 8'hA5; bus.load_hi = 8'h3C;
        cycle();
        bus.load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t5_valid", int'(bus.px_valid), 1);
            check("t5_shade_off", int'(bus.px_out), 0);
            cycle();
        end
        bg_enable = 1'b1;
        #1;
        check("t5_shade_on", int'(bus.px_out), 3);
        for (int i = 0; i < 4; i++) cycle();
        $display("t5 bg_enable done");

        // Asynchronous reset with 12 pixels stored
        palette = 8'hE4;
        bus.px_ready = 1'b0;
        bus.load_valid = 1'b1; bus.load_lo = 8'h33; bus.load_hi = 8'hF0;
        cycle();
        cycle();
        bus.load_valid = 1'b0;
        bus.px_ready = 1'b1;
        repeat (4) cycle();
        #1;
        check("t6_pre_count", int'(count), 12);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(bus.px_valid), 0);
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_ready", int'(bus.load_ready), 1);
        check("t6_rst_px_out", int'(bus.px_out), 0);
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) cycle();
        $display("t6 async reset done");

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.load_valid = 1'($urandom_range(0, 1));
            bus.load_lo    = 8'($urandom);
            bus.load_hi    = 8'($urandom);
            bus.px_ready   = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 299) == 0);
            discard_set    = ($urandom_range(0, 49) == 0);
            discard_n      = 3'($urandom);
            bg_enable      = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 63) == 0) palette = 8'($urandom);
            cycle();
        end
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
